// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath control, with a memory ready/timeout handshake.
module multicycle_control #(
  parameter int unsigned OP_WIDTH    = 6,
  parameter int unsigned ALUOP_WIDTH = 3,
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OP_WIDTH-1:0]    OP,
  input  logic                   mem_ready,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   PCWrite,
  output logic                   BranchEQ,
  output logic                   BranchNE,
  output logic [1:0]             PCSource,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [ALUOP_WIDTH-1:0] ALUOp,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   instr_done,
  output logic                   illegal_op,
  output logic                   mem_fault,
  output logic [3:0]             state
);

  localparam int unsigned CntW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [OP_WIDTH-1:0] OpRtype = OP_WIDTH'(6'h00);
  localparam logic [OP_WIDTH-1:0] OpJ     = OP_WIDTH'(6'h02);
  localparam logic [OP_WIDTH-1:0] OpBeq   = OP_WIDTH'(6'h04);
  localparam logic [OP_WIDTH-1:0] OpBne   = OP_WIDTH'(6'h05);
  localparam logic [OP_WIDTH-1:0] OpAddi  = OP_WIDTH'(6'h08);
  localparam logic [OP_WIDTH-1:0] OpOri   = OP_WIDTH'(6'h0D);
  localparam logic [OP_WIDTH-1:0] OpLw    = OP_WIDTH'(6'h23);
  localparam logic [OP_WIDTH-1:0] OpSw    = OP_WIDTH'(6'h2B);

  localparam logic [ALUOP_WIDTH-1:0] AluAdd  = ALUOP_WIDTH'(3'b000);
  localparam logic [ALUOP_WIDTH-1:0] AluSub  = ALUOP_WIDTH'(3'b001);
  localparam logic [ALUOP_WIDTH-1:0] AluOr   = ALUOP_WIDTH'(3'b101);
  localparam logic [ALUOP_WIDTH-1:0] AluAddi = ALUOP_WIDTH'(3'b110);
  localparam logic [ALUOP_WIDTH-1:0] AluFunc = ALUOP_WIDTH'(3'b111);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StRtExe, StRtWb, StIExe, StIWb, StBranch, StJump
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            ready;
  logic            in_mem_state;

  // With waiting disabled every memory access completes in its first cycle.
  assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    in_mem_state = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    BranchEQ     = 1'b0;
    BranchNE     = 1'b0;
    PCSource     = 2'b00;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = AluAdd;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;
    mem_fault    = 1'b0;
    state        = reset ? 4'd0 : state_q;

    // Reset forces every output low, so nothing is written in a reset cycle.
    if (!reset) begin
      unique case (state_q)
        StFetch: begin
          in_mem_state = 1'b1;
          MemRead      = 1'b1;
          ALUSrcB      = 2'b01;
          if (ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = StDecode;
          end
        end
        StDecode: begin
          ALUSrcB = 2'b11;
          case (OP)
            OpRtype:       state_d = StRtExe;
            OpAddi, OpOri: state_d = StIExe;
            OpLw, OpSw:    state_d = StMemAdr;
            OpBeq, OpBne:  state_d = StBranch;
            OpJ:           state_d = StJump;
            default: begin
              illegal_op = 1'b1;
              state_d    = StFetch;
            end
          endcase
        end
        StMemAdr: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = (OP == OpSw) ? StMemWr : StMemRd;
        end
        StMemRd: begin
          in_mem_state = 1'b1;
          IorD         = 1'b1;
          MemRead      = 1'b1;
          if (ready) state_d = StMemWb;
        end
        StMemWb: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StMemWr: begin
          in_mem_state = 1'b1;
          IorD         = 1'b1;
          MemWrite     = 1'b1;
          if (ready) begin
            instr_done = 1'b1;
            state_d    = StFetch;
          end
        end
        StRtExe: begin
          ALUSrcA = 1'b1;
          ALUOp   = AluFunc;
          state_d = StRtWb;
        end
        StRtWb: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StIExe: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = (OP == OpOri) ? AluOr : AluAddi;
          state_d = StIWb;
        end
        StIWb: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StBranch: begin
          ALUSrcA    = 1'b1;
          ALUOp      = AluSub;
          PCSource   = 2'b01;
          BranchEQ   = (OP == OpBeq);
          BranchNE   = (OP == OpBne);
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        StJump: begin
          PCSource   = 2'b10;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end
        default: state_d = StFetch;
      endcase

      // Stalled memory access: count the wait, or give up and refetch.
      if (in_mem_state && !ready) begin
        if (wait_cnt_q == CntW'(MEM_TIMEOUT)) begin
          mem_fault = 1'b1;
          state_d   = StFetch;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed vector table, hand-written corner sequences
// and randomized traffic checked against an instruction-level reference model.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] state;
    logic       iord, mem_read, mem_write, ir_write, pc_write, beq, bne;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal_op, mem_fault;
  } out_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic       done, ill, fault, mr, rw, irw;
  } vec_t;

  localparam int SFetch = 0, SDecode = 1, SMemAdr = 2, SMemRd = 3, SMemWb = 4, SMemWr = 5;
  localparam int SRtExe = 6, SRtWb = 7, SIExe = 8, SIWb = 9, SBranch = 10, SJump = 11;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] OP;
  logic mem_ready;

  logic [3:0] st0, st1;
  logic [1:0] pcs0, pcs1, asb0, asb1;
  logic [2:0] aop0, aop1;
  logic iord0, mr0, mw0, irw0, pcw0, beq0, bne0, asa0, rd0, m2r0, rw0, dn0, ill0, flt0;
  logic iord1, mr1, mw1, irw1, pcw1, beq1, bne1, asa1, rd1, m2r1, rw1, dn1, ill1, flt1;
  out_t act0, act1, smp0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state per instance: current step, planned steps, wait count.
  int m_cur[2], m_wcnt[2], m_len[2], m_pos[2];
  int m_plan[2][3];

  always #5 clk = ~clk;

  multicycle_control #(.OP_WIDTH(6), .ALUOP_WIDTH(3), .MEM_WAIT_EN(1'b1), .MEM_TIMEOUT(15))
  u_dut (
    .clk(clk), .reset(reset), .OP(OP), .mem_ready(mem_ready),
    .IorD(iord0), .MemRead(mr0), .MemWrite(mw0), .IRWrite(irw0), .PCWrite(pcw0),
    .BranchEQ(beq0), .BranchNE(bne0), .PCSource(pcs0), .ALUSrcA(asa0), .ALUSrcB(asb0),
    .ALUOp(aop0), .RegDst(rd0), .MemtoReg(m2r0), .RegWrite(rw0), .instr_done(dn0),
    .illegal_op(ill0), .mem_fault(flt0), .state(st0)
  );

  multicycle_control #(.OP_WIDTH(6), .ALUOP_WIDTH(3), .MEM_WAIT_EN(1'b0), .MEM_TIMEOUT(3))
  u_dut_nowait (
    .clk(clk), .reset(reset), .OP(OP), .mem_ready(mem_ready),
    .IorD(iord1), .MemRead(mr1), .MemWrite(mw1), .IRWrite(irw1), .PCWrite(pcw1),
    .BranchEQ(beq1), .BranchNE(bne1), .PCSource(pcs1), .ALUSrcA(asa1), .ALUSrcB(asb1),
    .ALUOp(aop1), .RegDst(rd1), .MemtoReg(m2r1), .RegWrite(rw1), .instr_done(dn1),
    .illegal_op(ill1), .mem_fault(flt1), .state(st1)
  );

  assign act0 = {st0, iord0, mr0, mw0, irw0, pcw0, beq0, bne0, pcs0, asa0, asb0, aop0,
                 rd0, m2r0, rw0, dn0, ill0, flt0};
  assign act1 = {st1, iord1, mr1, mw1, irw1, pcw1, beq1, bne1, pcs1, asa1, asb1, aop1,
                 rd1, m2r1, rw1, dn1, ill1, flt1};

  function automatic logic wait_en(input int i);
    return i == 0;
  endfunction

  function automatic int tmo_limit(input int i);
    return (i == 0) ? 15 : 3;
  endfunction

  function automatic out_t model_out(input int s, input logic [5:0] op, input logic rdy,
                                     input logic tmo, input logic rst);
    out_t o = '0;
    if (rst) return o;
    o.state = 4'(s);
    case (s)
      SFetch: begin
        o.mem_read = 1; o.alu_src_b = 2'b01;
        o.ir_write = rdy; o.pc_write = rdy; o.mem_fault = tmo;
      end
      SDecode: begin
        o.alu_src_b  = 2'b11;
        o.illegal_op = !(op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0D, 6'h23, 6'h2B});
      end
      SMemAdr: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      SMemRd:  begin o.iord = 1; o.mem_read = 1; o.mem_fault = tmo; end
      SMemWb:  begin o.mem_to_reg = 1; o.reg_write = 1; o.instr_done = 1; end
      SMemWr:  begin o.iord = 1; o.mem_write = 1; o.instr_done = rdy; o.mem_fault = tmo; end
      SRtExe:  begin o.alu_src_a = 1; o.alu_op = 3'b111; end
      SRtWb:   begin o.reg_dst = 1; o.reg_write = 1; o.instr_done = 1; end
      SIExe: begin
        o.alu_src_a = 1; o.alu_src_b = 2'b10;
        o.alu_op = (op == 6'h0D) ? 3'b101 : 3'b110;
      end
      SIWb: begin o.reg_write = 1; o.instr_done = 1; end
      SBranch: begin
        o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_source = 2'b01;
        o.beq = (op == 6'h04); o.bne = (op == 6'h05); o.instr_done = 1;
      end
      SJump: begin o.pc_source = 2'b10; o.pc_write = 1; o.instr_done = 1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic plan_instr(input int i, input logic [5:0] op);
    m_len[i] = 0;
    m_pos[i] = 0;
    case (op)
      6'h00:        begin m_plan[i][0] = SRtExe;  m_plan[i][1] = SRtWb; m_len[i] = 2; end
      6'h08, 6'h0D: begin m_plan[i][0] = SIExe;   m_plan[i][1] = SIWb;  m_len[i] = 2; end
      6'h23: begin
        m_plan[i][0] = SMemAdr; m_plan[i][1] = SMemRd; m_plan[i][2] = SMemWb; m_len[i] = 3;
      end
      6'h2B:        begin m_plan[i][0] = SMemAdr; m_plan[i][1] = SMemWr; m_len[i] = 2; end
      6'h04, 6'h05: begin m_plan[i][0] = SBranch; m_len[i] = 1; end
      6'h02:        begin m_plan[i][0] = SJump;   m_len[i] = 1; end
      default: ;
    endcase
  endtask

  task automatic model_advance(input int i, input logic r, input logic [5:0] op, input logic y);
    logic re;
    re = wait_en(i) ? y : 1'b1;
    if (r) begin
      m_cur[i] = SFetch; m_wcnt[i] = 0; m_len[i] = 0; m_pos[i] = 0;
      return;
    end
    if (m_cur[i] inside {SFetch, SMemRd, SMemWr} && !re) begin
      if (m_wcnt[i] == tmo_limit(i)) begin
        m_cur[i] = SFetch; m_wcnt[i] = 0;
      end else begin
        m_wcnt[i]++;
      end
      return;
    end
    m_wcnt[i] = 0;
    if (m_cur[i] == SFetch) begin
      m_cur[i] = SDecode;
    end else if (m_cur[i] == SDecode) begin
      plan_instr(i, op);
      m_cur[i] = (m_len[i] == 0) ? SFetch : m_plan[i][0];
    end else begin
      m_pos[i]++;
      m_cur[i] = (m_pos[i] < m_len[i]) ? m_plan[i][m_pos[i]] : SFetch;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: apply inputs, compare both DUTs to the model mid-cycle, then advance.
  task automatic step(input logic r, input logic [5:0] o, input logic y);
    logic re;
    out_t exp;
    reset = r; OP = o; mem_ready = y;
    @(negedge clk);
    smp0 = act0;
    for (int i = 0; i < 2; i++) begin
      re  = wait_en(i) ? y : 1'b1;
      exp = model_out(m_cur[i], o, re, !re && (m_wcnt[i] == tmo_limit(i)), r);
      check($sformatf("cyc%0d dut%0d outputs", cyc, i), (i == 0) ? 32'(act1 === act1 ? act0 : act0) : 32'(act1), 32'(exp));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) model_advance(i, r, o, y);
    cyc++;
  endtask

  vec_t vecs[21];
  logic [5:0] ops[9];

  initial begin
    int stuck;
    logic [5:0] cur_op;
    logic rdy, rst;
    reset = 1'b1; OP = '0; mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin m_cur[i] = SFetch; m_wcnt[i] = 0; m_len[i] = 0; m_pos[i] = 0; end

    //          rst op     rdy st  done ill flt mr rw irw
    vecs[0]  = '{1, 6'h00, 1, 4'd0,  0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 6'h00, 1, 4'd0,  0, 0, 0, 0, 0, 0};
    vecs[2]  = '{1, 6'h00, 1, 4'd0,  0, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 6'h00, 1, 4'd0,  0, 0, 0, 1, 0, 1};
    vecs[4]  = '{0, 6'h00, 1, 4'd1,  0, 0, 0, 0, 0, 0};
    vecs[5]  = '{0, 6'h00, 1, 4'd6,  0, 0, 0, 0, 0, 0};
    vecs[6]  = '{0, 6'h00, 1, 4'd7,  1, 0, 0, 0, 1, 0};
    vecs[7]  = '{0, 6'h23, 1, 4'd0,  0, 0, 0, 1, 0, 1};
    vecs[8]  = '{0, 6'h23, 1, 4'd1,  0, 0, 0, 0, 0, 0};
    vecs[9]  = '{0, 6'h23, 1, 4'd2,  0, 0, 0, 0, 0, 0};
    vecs[10] = '{0, 6'h23, 0, 4'd3,  0, 0, 0, 1, 0, 0};
    vecs[11] = '{0, 6'h23, 0, 4'd3,  0, 0, 0, 1, 0, 0};
    vecs[12] = '{0, 6'h23, 0, 4'd3,  0, 0, 0, 1, 0, 0};
    vecs[13] = '{0, 6'h23, 1, 4'd3,  0, 0, 0, 1, 0, 0};
    vecs[14] = '{0, 6'h23, 1, 4'd4,  1, 0, 0, 0, 1, 0};
    vecs[15] = '{0, 6'h05, 1, 4'd0,  0, 0, 0, 1, 0, 1};
    vecs[16] = '{0, 6'h05, 1, 4'd1,  0, 0, 0, 0, 0, 0};
    vecs[17] = '{0, 6'h05, 1, 4'd10, 1, 0, 0, 0, 0, 0};
    vecs[18] = '{0, 6'h3F, 1, 4'd0,  0, 0, 0, 1, 0, 1};
    vecs[19] = '{0, 6'h3F, 1, 4'd1,  0, 1, 0, 0, 0, 0};
    vecs[20] = '{0, 6'h00, 1, 4'd0,  0, 0, 0, 1, 0, 1};

    for (int v = 0; v < 21; v++) begin
      step(vecs[v].rst, vecs[v].op, vecs[v].rdy);
      check($sformatf("vec%0d state/flags", v),
            32'({smp0.state, smp0.instr_done, smp0.illegal_op, smp0.mem_fault,
                 smp0.mem_read, smp0.reg_write, smp0.ir_write}),
            32'({vecs[v].st, vecs[v].done, vecs[v].ill, vecs[v].fault,
                 vecs[v].mr, vecs[v].rw, vecs[v].irw}));
      if (vecs[v].rst) check($sformatf("vec%0d reset all-zero", v), 32'(smp0), 32'(0));
    end

    // FETCH stalled: fault on the 16th waiting cycle, then a fresh fetch.
    step(1'b1, 6'h00, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 6'h00, 1'b0);
      check($sformatf("timeout k%0d fault", k), 32'(smp0.mem_fault), 32'(k == 16));
      check($sformatf("timeout k%0d irwrite/state", k), 32'({smp0.ir_write, smp0.state}), 32'(0));
    end
    step(1'b0, 6'h00, 1'b0);
    check("timeout restart", 32'({smp0.mem_fault, smp0.state, smp0.mem_read}), 32'(1));

    // Reset landing in MEMWR must suppress the write.
    step(1'b1, 6'h2B, 1'b1);
    step(1'b0, 6'h2B, 1'b1);
    step(1'b0, 6'h2B, 1'b1);
    step(1'b0, 6'h2B, 1'b1);
    step(1'b1, 6'h2B, 1'b1);
    check("reset in MEMWR memwrite", 32'(smp0.mem_write), 32'(0));
    step(1'b0, 6'h2B, 1'b1);
    check("after reset state", 32'(smp0.state), 32'(0));

    ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h0D; ops[3] = 6'h23; ops[4] = 6'h2B;
    ops[5] = 6'h04; ops[6] = 6'h05; ops[7] = 6'h02; ops[8] = 6'h3F;
    stuck = 0;
    cur_op = 6'h00;
    for (int c = 0; c < 4000; c++) begin
      if (m_cur[0] == SFetch && m_cur[1] == SFetch) begin
        cur_op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      end
      if (stuck == 0 && $urandom_range(0, 99) < 3) stuck = $urandom_range(5, 20);
      if (stuck > 0) begin
        rdy = 1'b0;
        stuck--;
      end else begin
        rdy = ($urandom_range(0, 99) < 70);
      end
      rst = ($urandom_range(0, 199) == 0);
      step(rst, cur_op, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
